// File: rtl/disp_scan_pkg.sv
// disp_scan shared definitions: scan states, digit count and
// active-high 7-segment patterns (bit 0 = a ... bit 6 = g).
package disp_scan_pkg;

  localparam int NDIG = 6;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_e;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

  function automatic logic [5:0] dig_onehot(
    input logic [2:0] idx
  );
    logic [5:0] oh;
    oh = 6'd1 << idx;
    return oh;
  endfunction

endpackage

// File: rtl/disp_scan_bcd7seg.sv
// BCD nibble to active-high 7-segment pattern.
// Codes 10..15 render as a dash (segment g only).
module bcd7seg
  import disp_scan_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    unique case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/disp_scan.sv
// Six-digit multiplexed 7-segment scanner with inter-digit blanking.
// Optional pair blinking is built when DISP_BLINK_EN is defined.
module disp_scan
  import disp_scan_pkg::*;
#(
  parameter int DWELL          = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1,
  parameter int BLINK_HALF     = 500
) (
  input  logic        clk_1Khz,
  input  logic        rst,
  input  logic [23:0] dispbuf,
`ifdef DISP_BLINK_EN
  input  logic [2:0]  blink,
`endif
  output logic [6:0]  seg,
  output logic        dp,
  output logic [5:0]  dig_sel
);

  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic DIG_INV = (DIG_ACTIVE_LOW != 0);

  localparam logic [6:0] SEG_OFF = {7{SEG_INV}};
  localparam logic       DP_OFF  = SEG_INV;
  localparam logic [5:0] DIG_OFF = {6{DIG_INV}};

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
  localparam logic [2:0] IDX_LAST   = 3'(NDIG - 1);

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  dwell_q, dwell_d;
  logic [23:0] snap_q, snap_d;

  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic [5:0]  dig_q, dig_d;

  logic [3:0]  nib;
  logic [6:0]  pat;
  logic        seg_blank;

  always_ff @(posedge clk_1Khz or posedge rst) begin
    if (rst) begin
      state_q <= BLANK;
      idx_q   <= '0;
      dwell_q <= '0;
      snap_q  <= '0;
      seg_q   <= SEG_OFF;
      dp_q    <= DP_OFF;
      dig_q   <= DIG_OFF;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      snap_q  <= snap_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      dig_q   <= dig_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dwell_d = dwell_q;
    snap_d  = snap_q;
    unique case (state_q)
      BLANK: begin
        state_d = SHOW;
        dwell_d = '0;
        if (idx_q == 3'd0) snap_d = dispbuf;
      end
      SHOW: begin
        if (dwell_q == DWELL_LAST) begin
          state_d = BLANK;
          dwell_d = '0;
          idx_d   = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        end else begin
          dwell_d = dwell_q + 8'd1;
        end
      end
      default: state_d = BLANK;
    endcase
  end

`ifdef DISP_BLINK_EN
  localparam int CW = (2 * BLINK_HALF > 1) ? $clog2(2 * BLINK_HALF) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * BLINK_HALF - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(BLINK_HALF);

  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_1Khz or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    // idx[2:1] selects the HH/MM/SS pair of the digit being loaded
    seg_blank = (cnt_d >= CNT_HALF) && blink[idx_d[2:1]];
  end
`else
  assign seg_blank = 1'b0;
`endif

  assign nib = snap_d[idx_d*4 +: 4];

  bcd7seg u_dec (
    .bcd_i (nib),
    .seg_o (pat)
  );

  // Outputs are computed from next state so they line up with state_q
  always_comb begin
    seg_d = SEG_OFF;
    dp_d  = DP_OFF;
    dig_d = DIG_OFF;
    if (state_d == SHOW) begin
      dig_d = dig_onehot(idx_d) ^ {6{DIG_INV}};
      seg_d = (seg_blank ? 7'h00 : pat) ^ {7{SEG_INV}};
      dp_d  = ((idx_d == 3'd2) || (idx_d == 3'd4)) ^ SEG_INV;
    end
  end

  assign seg     = seg_q;
  assign dp      = dp_q;
  assign dig_sel = dig_q;

endmodule
